// File: rtl/transposed_convolution.sv
// ---------------------------------------------------------------------------
// transposed_convolution
//
// Scatters a streamed 2x2 feature map through one of four fixed binary 3x3
// kernels (stride 1) into a 4x4 result buffer, then streams the 16 results
// out row-major. Also flags whether the frame total exceeds THRESH.
//
// State table:
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_COLLECT | accepting x00,x01,x10,x11; each beat scatters into the buffer
//   S_EMIT    | presenting buffer cells y00..y33, one per out handshake
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active high
//   m_i          kernel select, latched on the first input beat of a frame
//   in_valid_i   input sample valid
//   in_ready_o   high only in S_COLLECT
//   in_data_i    input sample, row-major x00,x01,x10,x11
//   out_valid_o  high only in S_EMIT
//   out_ready_i  downstream accepts output
//   out_data_o   result y[r][c], row-major; zero when out_valid_o is low
//   out_last_o   high on the 16th beat (y33)
//   ans_o        frame total > THRESH; meaningful only while out_valid_o is high
// ---------------------------------------------------------------------------
module transposed_convolution #(
    parameter int DW     = 9,
    parameter int OW     = DW + 2,
    parameter int SW     = DW + 6,
    parameter int THRESH = 40
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [1:0]    m_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [OW-1:0] out_data_o,
    output logic          out_last_o,
    output logic          ans_o
);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] buf_q [16];
    logic [OW-1:0] buf_d [16];
    logic [SW-1:0] total_q, total_d;
    logic [3:0]    in_cnt_q, in_cnt_d;
    logic [3:0]    out_cnt_q, out_cnt_d;
    logic [1:0]    ksel_q, ksel_d;
    logic          ans_q, ans_d;

    logic [8:0]    kern;
    logic [3:0]    cell_idx;

    // Bit 8 is K[0][0], bit 0 is K[2][2].
    function automatic logic [8:0] kernel_of(input logic [1:0] sel);
        case (sel)
            2'd0:    kernel_of = 9'b100110000;
            2'd1:    kernel_of = 9'b000010111;
            2'd2:    kernel_of = 9'b111000111;
            default: kernel_of = 9'b111111111;
        endcase
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_COLLECT;
            buf_q     <= '{default: '0};
            total_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            ksel_q    <= '0;
            ans_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            total_q   <= total_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            ksel_q    <= ksel_d;
            ans_q     <= ans_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        total_d   = total_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        ksel_d    = ksel_q;
        ans_d     = ans_q;
        cell_idx  = '0;

        // The first beat has to use m_i directly: ksel_q only picks it up on that same edge.
        kern = kernel_of((in_cnt_q == 4'd0) ? m_i : ksel_q);

        case (state_q)
            S_COLLECT: begin
                if (in_valid_i) begin
                    if (in_cnt_q == 4'd0) begin
                        ksel_d = m_i;
                    end
                    // Sample x[i][j] with i=in_cnt[1], j=in_cnt[0] lands on y[i+a][j+b].
                    for (int a = 0; a < 3; a++) begin
                        for (int b = 0; b < 3; b++) begin
                            if (kern[8 - 3*a - b]) begin
                                cell_idx = 4'((int'(in_cnt_q[1]) + a) * 4 + int'(in_cnt_q[0]) + b);
                                buf_d[cell_idx] = buf_d[cell_idx] + OW'(in_data_i);
                                total_d = total_d + SW'(in_data_i);
                            end
                        end
                    end
                    in_cnt_d = in_cnt_q + 4'd1;
                    if (in_cnt_q == 4'd3) begin
                        state_d = S_EMIT;
                        ans_d   = (total_d > SW'(THRESH));
                    end
                end
            end
            S_EMIT: begin
                if (out_ready_i) begin
                    out_cnt_d = out_cnt_q + 4'd1;
                    if (out_cnt_q == 4'd15) begin
                        state_d   = S_COLLECT;
                        buf_d     = '{default: '0};
                        total_d   = '0;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    assign in_ready_o  = (state_q == S_COLLECT);
    assign out_valid_o = (state_q == S_EMIT);
    assign out_data_o  = (state_q == S_EMIT) ? buf_q[out_cnt_q] : '0;
    assign out_last_o  = (state_q == S_EMIT) && (out_cnt_q == 4'd15);
    assign ans_o       = (state_q == S_EMIT) && ans_q;

endmodule

// File: tb/tb_transposed_convolution.sv
module tb_transposed_convolution;

    localparam int DW = 9;
    localparam int OW = DW + 2;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          last;
        logic          ans;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    m;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          ans;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    int t1_vals[16] = '{1, 2, 0, 0, 4, 7, 2, 0, 3, 7, 4, 0, 0, 0, 0, 0};
    int t2_vals[16] = '{1, 3, 3, 2, 4, 10, 10, 6, 4, 10, 10, 6, 3, 7, 7, 4};

    always #5 clk = ~clk;

    transposed_convolution dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m_i         (m),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .ans_o       (ans)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [8:0] kern_tb(input logic [1:0] sel);
        case (sel)
            2'd0:    return 9'b100110000;
            2'd1:    return 9'b000010111;
            2'd2:    return 9'b111000111;
            default: return 9'b111111111;
        endcase
    endfunction

    // Gather formulation: y[r][c] = sum over x[i][j] * K[r-i][c-j].
    function automatic void push_model(input logic [1:0] sel, input int x0, input int x1,
                                       input int x2, input int x3);
        int         x[4];
        int         ya[16];
        int         total;
        logic [8:0] k;
        exp_t       e;
        x     = '{x0, x1, x2, x3};
        k     = kern_tb(sel);
        total = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ya[r*4+c] = 0;
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 2; j++) begin
                        if ((r - i) >= 0 && (r - i) <= 2 && (c - j) >= 0 && (c - j) <= 2) begin
                            if (k[8 - 3*(r-i) - (c-j)]) ya[r*4+c] += x[i*2+j];
                        end
                    end
                end
                total += ya[r*4+c];
            end
        end
        for (int n = 0; n < 16; n++) begin
            e.d    = OW'(ya[n]);
            e.last = (n == 15);
            e.ans  = (total > 40);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void push_lit(input int v[16], input logic a);
        exp_t e;
        for (int n = 0; n < 16; n++) begin
            e.d    = OW'(v[n]);
            e.last = (n == 15);
            e.ans  = a;
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_frame(input logic [1:0] m0, input logic [1:0] m_rest,
                              input int x0, input int x1, input int x2, input int x3);
        int x[4];
        x = '{x0, x1, x2, x3};
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("collect_in_ready", in_ready, 1);
            if (b == 3) check("pre_emit_out_valid", out_valid, 0);
            m        = (b == 0) ? m0 : m_rest;
            in_valid = 1'b1;
            in_data  = DW'(x[b]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("latency_out_valid", out_valid, 1);
        check("emit_entry_in_ready", in_ready, 0);
    endtask

    task automatic recv(input int nbeats, input bit toggle, input bit hold);
        int            popped = 0;
        int            cyc    = 0;
        bit            stalled = 0;
        bit            rdy_ph  = 1;
        bit            rdy;
        logic [OW-1:0] pd;
        logic          pl, pa;
        exp_t          e;
        while (popped < nbeats && cyc < 200) begin
            @(negedge clk);
            cyc++;
            check("emit_out_valid", out_valid, 1);
            check("emit_in_ready_low", in_ready, 0);
            if (stalled) begin
                check("stall_data_stable", out_data, pd);
                check("stall_last_stable", out_last, pl);
                check("stall_ans_stable", ans, pa);
            end
            rdy       = toggle ? rdy_ph : 1'b1;
            rdy_ph    = ~rdy_ph;
            out_ready = rdy;
            in_valid  = hold && (popped < 15);
            in_data   = 9'h155;
            if (rdy) begin
                stalled = 0;
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.last);
                    check("ans", ans, e.ans);
                end
                popped++;
            end else begin
                stalled = 1;
                pd = out_data;
                pl = out_last;
                pa = ans;
            end
        end
        if (popped < nbeats) check("recv_timeout", popped, nbeats);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (nbeats == 16) begin
            check("post_frame_in_ready", in_ready, 1);
            check("post_frame_out_valid", out_valid, 0);
            check("post_frame_out_data", out_data, 0);
            check("post_frame_out_last", out_last, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ans", ans, 0);
    endtask

    initial begin
        rst       = 1'b1;
        m         = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();

        // 1: m=0, literal vectors
        push_lit(t1_vals, 1'b0);
        send_frame(2'd0, 2'd0, 1, 2, 3, 4);
        recv(16, 0, 0);

        // 2: m=3, literal vectors
        push_lit(t2_vals, 1'b1);
        send_frame(2'd3, 2'd3, 1, 2, 3, 4);
        recv(16, 0, 0);

        // 3: full-scale samples, then m changed after beat 0
        push_model(2'd3, 511, 511, 511, 511);
        send_frame(2'd3, 2'd3, 511, 511, 511, 511);
        recv(16, 0, 0);
        push_model(2'd3, 5, 6, 7, 8);
        send_frame(2'd3, 2'd0, 5, 6, 7, 8);
        recv(16, 0, 0);

        // 4: test 1 under toggling backpressure, in_valid held during emit
        push_lit(t1_vals, 1'b0);
        send_frame(2'd0, 2'd0, 1, 2, 3, 4);
        recv(16, 1, 1);

        // 5: reset mid-collect, then mid-emit; clean frames afterwards
        @(negedge clk);
        m = 2'd1; in_valid = 1'b1; in_data = 9'd100;
        @(negedge clk);
        in_data = 9'd200;
        do_reset();
        push_lit(t2_vals, 1'b1);
        send_frame(2'd3, 2'd3, 1, 2, 3, 4);
        recv(16, 0, 0);
        push_lit(t2_vals, 1'b1);
        send_frame(2'd3, 2'd3, 1, 2, 3, 4);
        recv(5, 0, 0);
        exp_q.delete();
        do_reset();
        push_lit(t2_vals, 1'b1);
        send_frame(2'd3, 2'd3, 1, 2, 3, 4);
        recv(16, 0, 0);

        // 6: back-to-back frames with different kernels
        push_model(2'd1, 1, 2, 3, 4);
        send_frame(2'd1, 2'd1, 1, 2, 3, 4);
        recv(16, 0, 0);
        push_model(2'd2, 1, 2, 3, 4);
        send_frame(2'd2, 2'd2, 1, 2, 3, 4);
        recv(16, 0, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
